// File: rtl/pong_pkg.sv
// Shared definitions for the Pong game-flow controller: state encoding,
// BCD constants, default tick counts and the 2-digit BCD increment.
package pong_pkg;

    typedef enum logic [1:0] {
        ST_NEWGAME = 2'd0,
        ST_SERVE   = 2'd1,
        ST_PLAY    = 2'd2,
        ST_OVER    = 2'd3
    } game_state_t;

    localparam logic [7:0] BCD_ZERO = 8'h00;
    localparam logic [7:0] BCD_MAX  = 8'h99;

    localparam int DEF_SERVE_TICKS = 120;
    localparam int DEF_OVER_TICKS  = 180;

    // Two-digit BCD +1; ones wrap 9->0 with carry, whole value sticks at 99.
    function automatic logic [7:0] bcd_inc(input logic [7:0] value);
        logic [7:0] result;
        if (value == BCD_MAX)
            result = BCD_MAX;
        else if (value[3:0] == 4'd9)
            result = {value[7:4] + 4'd1, 4'd0};
        else
            result = {value[7:4], value[3:0] + 4'd1};
        return result;
    endfunction

endpackage

// File: rtl/bcd_counter2.sv
// Two-digit BCD counter with synchronous clear, increment enable and
// saturation at 99. Used for both scores and the rally count.
module bcd_counter2
    import pong_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       inc,
    output logic [7:0] count
);

    // Clear has priority over increment; saturate instead of wrapping.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register sampling the
        // pre-edge values, so ordering between always_ff blocks never matters.
        if (!reset || clr)
            count <= BCD_ZERO;
        else if (inc && count != BCD_MAX)
            count <= bcd_inc(count);
    end

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game-flow controller: sequences new-game, serve, play and game-over,
// and keeps the BCD scores and rally count for the overlay.
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter logic [7:0] WIN_SCORE   = 8'h07,
    parameter int         SERVE_TICKS = DEF_SERVE_TICKS,
    parameter int         OVER_TICKS  = DEF_OVER_TICKS
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic [3:0] btn,
    input  logic [1:0] hit,
    input  logic [1:0] miss,
    output logic       gra_still,
    output logic [1:0] game_state,
    output logic [7:0] score_l,
    output logic [7:0] score_r,
    output logic [7:0] rally,
    output logic [1:0] winner
);

    localparam logic [7:0] SERVE_LOAD = 8'(SERVE_TICKS);
    localparam logic [7:0] OVER_LOAD  = 8'(OVER_TICKS);

    game_state_t state;
    logic [7:0]  timer;
    logic [3:0]  btn_prev;
    logic        hit_done;

    logic start;
    logic in_play;
    logic miss_l;
    logic miss_r;
    logic hit_ok;
    logic l_wins;
    logic r_wins;
    logic timer_last;
    logic over_done;
    logic clr_scores;
    logic clr_rally;

    // Event decode: which status pulses count this cycle.
    always_comb begin
        start      = |(btn & ~btn_prev);
        in_play    = (state == ST_PLAY);
        miss_l     = in_play && miss[0];
        miss_r     = in_play && !miss[0] && miss[1];
        // A hit is taken once per frame interval and dropped if a miss coincides.
        hit_ok     = in_play && (miss == 2'b00) && (|hit) && !hit_done;
        l_wins     = (bcd_inc(score_l) == WIN_SCORE);
        r_wins     = (bcd_inc(score_r) == WIN_SCORE);
        timer_last = frame_tick && (timer == 8'd1);
        over_done  = (state == ST_OVER) && timer_last;
        // Clearing on the OVER exit edge makes the scores read zero on NEWGAME entry.
        clr_scores = (state == ST_NEWGAME) || over_done;
        clr_rally  = clr_scores || miss_l || miss_r;
    end

    // Game-phase FSM with registered freeze, winner, timer and edge detector.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= ST_NEWGAME;
            gra_still <= 1'b1;
            winner    <= 2'b00;
            timer     <= 8'd0;
            btn_prev  <= 4'd0;
            hit_done  <= 1'b0;
        end else begin
            btn_prev <= btn;
            if (state != ST_PLAY)
                hit_done <= 1'b0;
            case (state)
                ST_NEWGAME: begin
                    gra_still <= 1'b1;
                    winner    <= 2'b00;
                    if (start) begin
                        state <= ST_SERVE;
                        timer <= SERVE_LOAD;
                    end
                end
                ST_SERVE: begin
                    gra_still <= 1'b1;
                    if (timer_last) begin
                        state     <= ST_PLAY;
                        gra_still <= 1'b0;
                        timer     <= 8'd0;
                    end else if (frame_tick && timer != 8'd0) begin
                        timer <= timer - 8'd1;
                    end
                end
                ST_PLAY: begin
                    gra_still <= 1'b0;
                    if (miss_l || miss_r) begin
                        gra_still <= 1'b1;
                        if ((miss_l && l_wins) || (miss_r && r_wins)) begin
                            state  <= ST_OVER;
                            winner <= miss_l ? 2'b01 : 2'b10;
                            timer  <= OVER_LOAD;
                        end else begin
                            state <= ST_SERVE;
                            timer <= SERVE_LOAD;
                        end
                    end else if (hit_ok) begin
                        hit_done <= 1'b1;
                    end else if (frame_tick) begin
                        hit_done <= 1'b0;
                    end
                end
                ST_OVER: begin
                    gra_still <= 1'b1;
                    if (timer_last) begin
                        state  <= ST_NEWGAME;
                        winner <= 2'b00;
                        timer  <= 8'd0;
                    end else if (frame_tick && timer != 8'd0) begin
                        timer <= timer - 8'd1;
                    end
                end
                default: state <= ST_NEWGAME;
            endcase
        end
    end

    assign game_state = state;

    bcd_counter2 u_score_l (
        .clk   (clk),
        .reset (reset),
        .clr   (clr_scores),
        .inc   (miss_l),
        .count (score_l)
    );

    bcd_counter2 u_score_r (
        .clk   (clk),
        .reset (reset),
        .clr   (clr_scores),
        .inc   (miss_r),
        .count (score_r)
    );

    bcd_counter2 u_rally (
        .clk   (clk),
        .reset (reset),
        .clr   (clr_rally),
        .inc   (hit_ok),
        .count (rally)
    );

endmodule
